// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS control path.
// Holds opcode values, the 3-bit ALUOp encoding that alu_control_unit decodes,
// datapath mux select encodings, memory access sizes, the opcode class type
// and the bundle of Moore control outputs.
package mips_defs;

    // Opcode field IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALUOp bus towards alu_control_unit
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_REG  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BROFF = 2'b11;

    // Immediate extension select
    localparam logic [1:0] IMM_SEXT = 2'b00;
    localparam logic [1:0] IMM_ZEXT = 2'b01;
    localparam logic [1:0] IMM_LUI  = 2'b10;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Memory access size
    localparam logic [1:0] MSZ_WORD = 2'b00;
    localparam logic [1:0] MSZ_HALF = 2'b01;
    localparam logic [1:0] MSZ_BYTE = 2'b10;

    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5,
        CLS_JUMP    = 3'd6
    } op_class_t;

    // Registered Moore outputs (ir_write and illegal_op are handled separately)
    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_sel;
        logic       pc_write;
        logic       pc_write_cond;
        logic       bne_sel;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/mips_opcode_class.sv
// Combinational opcode classifier.
// Ports: opcode (IR[31:26]) in; op_class, alu_op (I-type ALU function),
// imm_sel (immediate extension) and mem_size (load/store width) out.
// Unknown opcodes classify as CLS_ILLEGAL.
module mips_opcode_class
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] alu_op,
    output logic [1:0] imm_sel,
    output logic [1:0] mem_size
);

    // Opcode table lookup
    always_comb begin
        op_class = CLS_ILLEGAL;
        alu_op   = ALUOP_ADD;
        imm_sel  = IMM_SEXT;
        mem_size = MSZ_WORD;
        case (opcode)
            OP_RTYPE:           op_class = CLS_R;
            OP_ADDI, OP_ADDIU:  op_class = CLS_I;
            OP_SLTI, OP_SLTIU: begin
                op_class = CLS_I;
                alu_op   = ALUOP_SLT;
            end
            OP_ANDI: begin
                op_class = CLS_I;
                alu_op   = ALUOP_AND;
                imm_sel  = IMM_ZEXT;
            end
            OP_ORI: begin
                op_class = CLS_I;
                alu_op   = ALUOP_OR;
                imm_sel  = IMM_ZEXT;
            end
            OP_LUI: begin
                op_class = CLS_I;
                imm_sel  = IMM_LUI;
            end
            OP_LW:              op_class = CLS_LOAD;
            OP_LHU: begin
                op_class = CLS_LOAD;
                mem_size = MSZ_HALF;
            end
            OP_LBU: begin
                op_class = CLS_LOAD;
                mem_size = MSZ_BYTE;
            end
            OP_SW:              op_class = CLS_STORE;
            OP_SH: begin
                op_class = CLS_STORE;
                mem_size = MSZ_HALF;
            end
            OP_SB: begin
                op_class = CLS_STORE;
                mem_size = MSZ_BYTE;
            end
            OP_BEQ, OP_BNE:     op_class = CLS_BRANCH;
            OP_J:               op_class = CLS_JUMP;
            default:            op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Ports: clk, rst_n (async active-low), opcode (IR[31:26]), mem_ready (memory
// handshake) in; ALU/mux selects, PC/IR/register/memory enables, mem_size and
// an illegal_op pulse out. Outputs are Moore: they are computed from the next
// state and registered, so they line up with the state they belong to. Only
// pc_write/ir_write in FETCH (qualified by mem_ready) and illegal_op (decoded
// from the freshly loaded IR) are combinational on top of the state register.
module mips_multicycle_control
    import mips_defs::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int ALUOP_W       = 3
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         imm_sel,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               bne_sel,
    output logic [1:0]         pc_source,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic [1:0]         mem_size,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_ALUWB_R = 4'd4,
        S_EXEC_I  = 4'd5,
        S_ALUWB_I = 4'd6,
        S_MEMADR  = 4'd7,
        S_MEMRD   = 4'd8,
        S_MEMWB   = 4'd9,
        S_MEMWR   = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    ctrl_t      ctrl_r;
    ctrl_t      ctrl_nxt_s;

    op_class_t  dec_class_s;
    logic [2:0] dec_alu_op_s;
    logic [1:0] dec_imm_sel_s;
    logic [1:0] dec_mem_size_s;

    op_class_t  class_r;
    logic [2:0] alu_op_lat_r;
    logic [1:0] imm_sel_lat_r;
    logic [1:0] mem_size_lat_r;
    logic       bne_lat_r;

    op_class_t  class_s;
    logic [2:0] alu_op_i_s;
    logic [1:0] imm_sel_i_s;
    logic [1:0] mem_size_i_s;
    logic       bne_s;
    logic       ready_s;

    mips_opcode_class u_opcode_class (
        .opcode   (opcode),
        .op_class (dec_class_s),
        .alu_op   (dec_alu_op_s),
        .imm_sel  (dec_imm_sel_s),
        .mem_size (dec_mem_size_s)
    );

    assign ready_s = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    // Opcode info: live decode while in DECODE, latched copy afterwards
    always_comb begin
        if (state_r == S_DECODE) begin
            class_s      = dec_class_s;
            alu_op_i_s   = dec_alu_op_s;
            imm_sel_i_s  = dec_imm_sel_s;
            mem_size_i_s = dec_mem_size_s;
            bne_s        = opcode[0];
        end else begin
            class_s      = class_r;
            alu_op_i_s   = alu_op_lat_r;
            imm_sel_i_s  = imm_sel_lat_r;
            mem_size_i_s = mem_size_lat_r;
            bne_s        = bne_lat_r;
        end
    end

    // Next-state sequencing
    always_comb begin
        state_nxt_s = S_IDLE;
        case (state_r)
            S_IDLE:    state_nxt_s = S_FETCH;
            S_FETCH:   state_nxt_s = ready_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (dec_class_s)
                    CLS_R:      state_nxt_s = S_EXEC_R;
                    CLS_I:      state_nxt_s = S_EXEC_I;
                    CLS_LOAD:   state_nxt_s = S_MEMADR;
                    CLS_STORE:  state_nxt_s = S_MEMADR;
                    CLS_BRANCH: state_nxt_s = S_BRANCH;
                    CLS_JUMP:   state_nxt_s = S_JUMP;
                    default:    state_nxt_s = S_FETCH;
                endcase
            end
            S_EXEC_R:  state_nxt_s = S_ALUWB_R;
            S_ALUWB_R: state_nxt_s = S_FETCH;
            S_EXEC_I:  state_nxt_s = S_ALUWB_I;
            S_ALUWB_I: state_nxt_s = S_FETCH;
            S_MEMADR:  state_nxt_s = (class_s == CLS_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_nxt_s = ready_s ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_nxt_s = S_FETCH;
            S_MEMWR:   state_nxt_s = ready_s ? S_FETCH : S_MEMWR;
            S_BRANCH:  state_nxt_s = S_FETCH;
            S_JUMP:    state_nxt_s = S_FETCH;
            default:   state_nxt_s = S_IDLE;
        endcase
    end

    // Output decode for the state being entered
    always_comb begin
        ctrl_nxt_s = '0;
        case (state_nxt_s)
            S_FETCH: begin
                ctrl_nxt_s.mem_read  = 1'b1;
                ctrl_nxt_s.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:  ctrl_nxt_s.alu_src_b = SRCB_BROFF;
            S_EXEC_R: begin
                ctrl_nxt_s.alu_src_a = SRCA_REG;
                ctrl_nxt_s.alu_src_b = SRCB_REG;
                ctrl_nxt_s.alu_op    = ALUOP_RTYPE;
            end
            S_ALUWB_R: begin
                ctrl_nxt_s.reg_dst   = 1'b1;
                ctrl_nxt_s.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                // lui adds the shifted immediate to zero instead of rs
                if (imm_sel_i_s == IMM_LUI) begin
                    ctrl_nxt_s.alu_src_a = SRCA_ZERO;
                end else begin
                    ctrl_nxt_s.alu_src_a = SRCA_REG;
                end
                ctrl_nxt_s.alu_src_b = SRCB_IMM;
                ctrl_nxt_s.alu_op    = alu_op_i_s;
                ctrl_nxt_s.imm_sel   = imm_sel_i_s;
            end
            S_ALUWB_I: ctrl_nxt_s.reg_write = 1'b1;
            S_MEMADR: begin
                ctrl_nxt_s.alu_src_a = SRCA_REG;
                ctrl_nxt_s.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_nxt_s.i_or_d   = 1'b1;
                ctrl_nxt_s.mem_read = 1'b1;
                ctrl_nxt_s.mem_size = mem_size_i_s;
            end
            S_MEMWB: begin
                ctrl_nxt_s.mem_to_reg = 1'b1;
                ctrl_nxt_s.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl_nxt_s.i_or_d    = 1'b1;
                ctrl_nxt_s.mem_write = 1'b1;
                ctrl_nxt_s.mem_size  = mem_size_i_s;
            end
            S_BRANCH: begin
                ctrl_nxt_s.alu_src_a     = SRCA_REG;
                ctrl_nxt_s.alu_src_b     = SRCB_REG;
                ctrl_nxt_s.alu_op        = ALUOP_SUB;
                ctrl_nxt_s.pc_write_cond = 1'b1;
                ctrl_nxt_s.pc_source     = PCSRC_ALUOUT;
                ctrl_nxt_s.bne_sel       = bne_s;
            end
            S_JUMP: begin
                ctrl_nxt_s.pc_source = PCSRC_JUMP;
                ctrl_nxt_s.pc_write  = 1'b1;
            end
            default:   ctrl_nxt_s = '0;
        endcase
    end

    // State, registered outputs and opcode-class latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            ctrl_r         <= '0;
            class_r        <= CLS_ILLEGAL;
            alu_op_lat_r   <= ALUOP_ADD;
            imm_sel_lat_r  <= IMM_SEXT;
            mem_size_lat_r <= MSZ_WORD;
            bne_lat_r      <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ctrl_r  <= ctrl_nxt_s;
            if (state_r == S_DECODE) begin
                class_r        <= dec_class_s;
                alu_op_lat_r   <= dec_alu_op_s;
                imm_sel_lat_r  <= dec_imm_sel_s;
                mem_size_lat_r <= dec_mem_size_s;
                bne_lat_r      <= opcode[0];
            end
        end
    end

    assign alu_op        = ctrl_r.alu_op;
    assign alu_src_a     = ctrl_r.alu_src_a;
    assign alu_src_b     = ctrl_r.alu_src_b;
    assign imm_sel       = ctrl_r.imm_sel;
    assign pc_write_cond = ctrl_r.pc_write_cond;
    assign bne_sel       = ctrl_r.bne_sel;
    assign pc_source     = ctrl_r.pc_source;
    assign i_or_d        = ctrl_r.i_or_d;
    assign mem_read      = ctrl_r.mem_read;
    assign mem_write     = ctrl_r.mem_write;
    assign mem_size      = ctrl_r.mem_size;
    assign reg_dst       = ctrl_r.reg_dst;
    assign mem_to_reg    = ctrl_r.mem_to_reg;
    assign reg_write     = ctrl_r.reg_write;

    // PC/IR load only in the fetch cycle where memory delivers the word
    assign ir_write   = (state_r == S_FETCH) && ready_s;
    assign pc_write   = ctrl_r.pc_write || ((state_r == S_FETCH) && ready_s);
    assign illegal_op = (state_r == S_DECODE) && (dec_class_s == CLS_ILLEGAL);

endmodule
